// File: rtl/aes_frame_loader.sv
// Byte-serial frame loader for the AES cores: collects an optional key phase and a
// 16-byte data phase, then holds the assembled block/key/round count until taken.
module aes_frame_loader #(
    parameter int DATA_BYTES = 16,
    parameter int KEY_W      = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         key_sel,
    input  logic               key_reuse,
    input  logic               abort,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [127:0]       out_block,
    output logic [KEY_W-1:0]   out_key,
    output logic [3:0]         out_nr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               key_loaded
);

    typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} state_t;

    state_t             state_q;
    logic [4:0]         cnt_q;
    logic [1:0]         ksel_q;
    logic [127:0]       out_block_q;
    logic [KEY_W-1:0]   out_key_q;
    logic [3:0]         out_nr_q;
    logic               out_valid_q;
    logic               key_loaded_q;

    logic               accept;
    logic [4:0]         key_last;
    logic [7:0]         key_hi;
    logic [6:0]         blk_hi;

    assign in_ready = (state_q != HOLD) && !abort;
    assign accept   = in_valid && in_ready;

    // MSB-first placement: byte n lands n bytes below the top of its bus.
    assign key_hi = 8'd255 - {cnt_q, 3'b000};
    assign blk_hi = 7'd127 - {cnt_q[3:0], 3'b000};

    always_comb begin
        key_last = 5'd31;
        case (ksel_q)
            2'b00:   key_last = 5'd15;
            2'b01:   key_last = 5'd23;
            default: key_last = 5'd31;
        endcase
    end

    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        case (ks)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ksel_q       <= '0;
            out_block_q  <= '0;
            out_key_q    <= '0;
            out_nr_q     <= 4'd10;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
        end else if (abort) begin
            // A stored key survives an abort unless it was still being written.
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            if (state_q == KEY) key_loaded_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    ksel_q   <= key_sel;
                    out_nr_q <= nr_of(key_sel);
                    cnt_q    <= 5'd1;
                    if (key_reuse && key_loaded_q) begin
                        out_block_q[127:120] <= in_byte;
                        state_q              <= DATA;
                    end else begin
                        out_key_q    <= {in_byte, {(KEY_W-8){1'b0}}};
                        key_loaded_q <= 1'b0;
                        state_q      <= KEY;
                    end
                end
                KEY: if (accept) begin
                    out_key_q[key_hi -: 8] <= in_byte;
                    if (cnt_q == key_last) begin
                        key_loaded_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DATA: if (accept) begin
                    out_block_q[blk_hi -: 8] <= in_byte;
                    if (cnt_q == 5'(DATA_BYTES - 1)) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_block  = out_block_q;
    assign out_key    = out_key_q;
    assign out_nr     = out_nr_q;
    assign out_valid  = out_valid_q;
    assign key_loaded = key_loaded_q;

endmodule

// File: doc/aes_frame_loader.md
Name: aes_frame_loader

Overview:
- Byte-serial front end for the AES encrypt/decrypt cores.
- Accepts a frame of key bytes followed by 16 data bytes over a valid/ready byte interface.
- Assembles the 128-bit block and the left-aligned 256-bit key, and selects the round count (10/12/14).
- Holds the assembled frame on a valid/ready output until the core takes it. This feeds the input side of the pipeline; the HEX display path reads the output side.

Parameters:
- DATA_BYTES, 16, data bytes per frame (fixed by AES, not to be overridden).
- KEY_W, 256, width of the out_key bus (maximum key size).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_sel  in  2  key size: 00 = 128-bit, 01 = 192-bit, 10/11 = 256-bit. Sampled on the first byte of a frame.
- key_reuse  in  1  sampled on the first byte: skip the key phase and reuse the stored key.
- abort  in  1  synchronous discard of the current frame.
- in_byte  in  8  frame byte, MSB-first order.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- out_block  out  128  assembled data block.
- out_key  out  256  assembled key, left-aligned.
- out_nr  out  4  round count: 10, 12 or 14.
- out_valid  out  1  frame complete and held.
- out_ready  in  1  downstream takes the frame.
- key_loaded  out  1  a complete key is stored.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; cnt = 0; out_block = 0; out_key = 0; out_nr = 10; out_valid = 0; key_loaded = 0.
- Byte accept: a byte is accepted when in_valid && in_ready.
- in_ready is combinational: 1 in IDLE, KEY and DATA when abort = 0; 0 in HOLD and whenever abort = 1.
- Key length klen: 16, 24 or 32 bytes, from the key_sel value latched on the first accepted byte.
- IDLE, on accept:
  - Latch key_sel and set out_nr to 10, 12 or 14.
  - If key_reuse = 1 and key_loaded = 1: store the byte at out_block[127:120], set cnt = 1, go to DATA. The latched key_sel must match the stored key; that match is the sender's responsibility and is not checked.
  - Otherwise: clear out_key to 0, clear key_loaded, store the byte at out_key[255:248], set cnt = 1, go to KEY.
- KEY: byte k goes to out_key[255-8k -: 8]. On accepting byte klen-1: set key_loaded = 1, cnt = 0, go to DATA. For a 128-bit key out_key[127:0] stays 0; for a 192-bit key out_key[63:0] stays 0.
- DATA: byte d goes to out_block[127-8d -: 8]. On accepting byte 15: go to HOLD and set out_valid = 1 in the next cycle. Latency is one cycle from the last accepted byte to out_valid.
- HOLD:
  - out_block, out_key and out_nr stay stable while out_valid = 1.
  - On out_valid && out_ready: out_valid = 0 and state returns to IDLE in the same edge.
  - No byte can be accepted in the handshake cycle, because in_ready = 0 in HOLD.
- abort = 1 (priority over all other events in the same cycle):
  - Go to IDLE, cnt = 0, out_valid = 0.
  - In KEY: also clear key_loaded; the partial key is invalid.
  - In DATA or HOLD: key_loaded is kept, so the stored key stays reusable.
- Changes to key_sel or key_reuse after the first byte of a frame are ignored until the next frame.
- in_valid while in HOLD: the byte is not consumed and the sender must hold it.
- cnt is 5 bits and never wraps: its maximum is 31, reached in KEY for a 256-bit key.
- Reset asserted mid-frame: immediate return to reset values; no partial output stays visible.

Test Plan:
- 256-bit frame: key_sel = 10, key 000102…1e1f, data 00112233…eeff, in_valid held high. Required: 48 accepts, out_valid in the cycle after the 48th, out_key = 000102…1f, out_block = 00112233…eeff, out_nr = 14.
- 128-bit frame: key_sel = 00, key 000102…0f. Required: out_key = 000102…0f followed by 128 zero bits, out_nr = 10. Then key_sel = 01 with a 24-byte key: out_key[63:0] = 0 and out_nr = 12.
- Backpressure: out_ready = 0 for 5 cycles with in_valid high. Required: in_ready = 0, outputs stable, no bytes lost. Raising out_ready drops out_valid next cycle and the next frame's first byte is accepted after that.
- Key reuse: after a 256-bit frame, key_reuse = 1 with 16 data bytes ffeeddcc…0011. Required: out_valid after 16 accepts, out_key unchanged.
- Abort mid-key at byte 10: required key_loaded = 0 and state IDLE; a following key_reuse = 1 frame takes the full key path. Abort mid-data: key_loaded stays 1.
- Async reset pulsed in DATA at byte 7: required all outputs at reset values immediately; the next frame assembles correctly.
